// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared channel constants, select type and slot state encoding
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // One-hot decode of a channel select.
  function automatic logic [NUM_CH-1:0] sel_decode(input ch_sel_t sel);
    logic [NUM_CH-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/demux4_stream_if.sv
// rtl/demux4_stream_if.sv - input stream, four output slots and counter bus
interface demux4_stream_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  import demux_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  ch_sel_t                  in_sel;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     clear_counts;
  logic [NUM_CH*CNT_W-1:0]  out_count;

  // master is the source/sink environment, slave is the demultiplexer.
  modport master (
    output in_valid, in_data, in_sel, out_ready, clear_counts,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, clear_counts,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output slot with load/drain FSM and delivered counter
module demux_slot #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  input  logic              clear,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);
  import demux_pkg::*;

  slot_state_t state;
  logic        deliver;

  assign valid   = (state == FULL);
  assign deliver = valid & ready;

  // The top only loads a full slot when it is draining the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state <= FULL;
            data  <= load_data;
          end
        end
        FULL: begin
          if (load) begin
            data <= load_data;
          end else if (ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (deliver) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - registered 1-to-4 stream demultiplexer top level
module demux4_stream #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  demux4_stream_if.slave   bus
);
  import demux_pkg::*;

  logic                     accept;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH-1:0]        valid_v;
  logic [NUM_CH*DATA_W-1:0] data_v;
  logic [NUM_CH*CNT_W-1:0]  count_v;

  // Only the addressed channel can stall the input stream.
  assign bus.in_ready = rst_n & (~valid_v[bus.in_sel] | bus.out_ready[bus.in_sel]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load         = accept ? sel_decode(bus.in_sel) : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (bus.in_data),
      .ready     (bus.out_ready[k]),
      .clear     (bus.clear_counts),
      .valid     (valid_v[k]),
      .data      (data_v[k*DATA_W +: DATA_W]),
      .count     (count_v[k*CNT_W +: CNT_W])
    );
  end

  assign bus.out_valid = valid_v;
  assign bus.out_data  = data_v;
  assign bus.out_count = count_v;

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - directed and random-soak bench for demux4_stream
module tb_demux4_stream;
  import demux_pkg::*;

  localparam int DW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux4_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  demux4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] fifo [NUM_CH][16];
  int head [NUM_CH];
  int tail [NUM_CH];
  int cnt_m [NUM_CH];

  initial begin
    int bad, stalls, mism, acc;
    bit hold;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_sel       = '0;
    bus.out_ready    = '0;
    bus.clear_counts = 1'b0;
    repeat (2) tick();
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    check("reset_ready", 32'(bus.in_ready), 32'h0);
    check("reset_count", bus.out_count, 32'h0);
    rst_n = 1'b1;
    #1;
    check("release_ready", 32'(bus.in_ready), 32'h1);

    // Basic routing, one word per channel.
    bus.out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = ch_sel_t'(i);
      bus.in_data  = 4'(i + 1);
      tick();
      check("route_valid", 32'(bus.out_valid), 32'(1 << i));
      check("route_data", 32'(bus.out_data[i*DW +: DW]), 32'(i + 1));
    end
    bus.in_valid = 1'b0;
    tick();
    check("route_empty", 32'(bus.out_valid), 32'h0);
    check("route_counts", bus.out_count, 32'h01010101);

    // Backpressure on channel 1 only.
    bus.out_ready = 4'b1101;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd1;
    bus.in_data   = 4'h5;
    #1;
    check("bp_first_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    #1;
    check("bp_other_ready", 32'(bus.in_ready), 32'h1);
    bus.in_sel = 2'd1;
    #1;
    check("bp_blocked_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h6;
    #1;
    check("bp_stall_ready", 32'(bus.in_ready), 32'h0);
    check("bp_hold_valid", 32'(bus.out_valid), 32'h2);
    check("bp_hold_data", 32'(bus.out_data[7:4]), 32'h5);
    tick();
    check("bp_hold_data2", 32'(bus.out_data[7:4]), 32'h5);
    check("bp_still_stalled", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 4'hF;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_second_data", 32'(bus.out_data[7:4]), 32'h6);
    check("bp_second_valid", 32'(bus.out_valid), 32'h2);
    bus.in_sel  = 2'd3;
    bus.in_data = 4'h7;
    #1;
    check("bp_sel3_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_sel3_valid", 32'(bus.out_valid), 32'h8);
    check("bp_sel3_data", 32'(bus.out_data[15:12]), 32'h7);
    bus.in_valid = 1'b0;
    tick();
    check("bp_counts", bus.out_count, 32'h02010301);

    // Pass-through on channel 2.
    bus.out_ready = 4'b1011;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd2;
    bus.in_data   = 4'h8;
    tick();
    check("pt_full_valid", 32'(bus.out_valid), 32'h4);
    check("pt_full_data", 32'(bus.out_data[11:8]), 32'h8);
    bus.out_ready = 4'hF;
    bus.in_data   = 4'h9;
    #1;
    check("pt_ready", 32'(bus.in_ready), 32'h1);
    tick();
    check("pt_valid", 32'(bus.out_valid), 32'h4);
    check("pt_data", 32'(bus.out_data[11:8]), 32'h9);
    check("pt_count", 32'(bus.out_count[23:16]), 32'h2);
    bus.in_valid = 1'b0;
    tick();
    check("pt_count_final", 32'(bus.out_count[23:16]), 32'h3);
    check("pt_empty", 32'(bus.out_valid), 32'h0);

    // Build slot2=A with count2=5, then reset mid-cycle.
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 4'h1;
    tick();
    bus.in_data = 4'h2;
    tick();
    bus.in_data = 4'hA;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b1011;
    tick();
    check("pre_rst_valid", 32'(bus.out_valid), 32'h4);
    check("pre_rst_data", 32'(bus.out_data[11:8]), 32'hA);
    check("pre_rst_count", 32'(bus.out_count[23:16]), 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_count", bus.out_count, 32'h0);
    check("rst_data", 32'(bus.out_data), 32'h0);
    check("rst_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 4'h3;
    tick();
    check("rst_held_ready", 32'(bus.in_ready), 32'h0);
    check("rst_held_valid", 32'(bus.out_valid), 32'h0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.in_ready), 32'h1);

    // 256 back-to-back words on channel 0: full throughput and counter wrap.
    bus.out_ready = 4'hF;
    bad    = 0;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd0;
      bus.in_data  = 4'(i);
      #1;
      if (bus.in_ready !== 1'b1) stalls++;
      if (i > 0 && (bus.out_valid[0] !== 1'b1 || bus.out_data[3:0] !== 4'(i - 1))) bad++;
      tick();
    end
    check("wrap_stalls", 32'(stalls), 32'h0);
    check("wrap_stream", 32'(bad), 32'h0);
    check("wrap_count_255", 32'(bus.out_count[7:0]), 32'hFF);
    bus.in_valid = 1'b0;
    tick();
    check("wrap_count_0", 32'(bus.out_count[7:0]), 32'h0);

    // clear_counts wins over a same-cycle delivery.
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd0;
    bus.in_data  = 4'hC;
    tick();
    bus.in_valid     = 1'b0;
    bus.clear_counts = 1'b1;
    #1;
    check("clr_deliver_valid", 32'(bus.out_valid), 32'h1);
    tick();
    bus.clear_counts = 1'b0;
    check("clr_counts", bus.out_count, 32'h0);
    check("clr_empty", 32'(bus.out_valid), 32'h0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("clr_recount", bus.out_count, 32'h00000001);

    // Random soak against a per-channel scoreboard.
    bus.clear_counts = 1'b1;
    tick();
    bus.clear_counts = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      head[k]  = 0;
      tail[k]  = 0;
      cnt_m[k] = 0;
    end
    mism = 0;
    acc  = 0;
    hold = 1'b0;
    for (int c = 0; c < 10010; c++) begin
      if (c < 10000) begin
        if (!hold) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_sel   = ch_sel_t'($urandom_range(0, 3));
          bus.in_data  = 4'($urandom_range(0, 15));
        end
        bus.out_ready = 4'($urandom_range(0, 15));
      end else begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'hF;
      end
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.out_valid[k] === 1'b1 && bus.out_ready[k]) begin
          if (tail[k] == head[k]) begin
            mism++;
          end else begin
            if (bus.out_data[k*DW +: DW] !== fifo[k][head[k] % 16]) mism++;
            head[k]++;
          end
          cnt_m[k]++;
        end
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        fifo[bus.in_sel][tail[bus.in_sel] % 16] = bus.in_data;
        tail[bus.in_sel]++;
        acc++;
        hold = 1'b0;
      end else begin
        hold = bus.in_valid;
      end
      tick();
    end
    check("soak_order", 32'(mism), 32'h0);
    check("soak_activity", 32'(acc > 1000), 32'h1);
    check("soak_drained", 32'(bus.out_valid), 32'h0);
    for (int k = 0; k < NUM_CH; k++) begin
      check("soak_no_loss", 32'(tail[k] - head[k]), 32'h0);
      check("soak_count", 32'(bus.out_count[k*CW +: CW]), 32'(cnt_m[k] % 256));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux4_stream.md
# demux4_stream

Registered 1-to-4 stream demultiplexer: the inverse of the ALU operand-select mux. A single valid/ready input stream carries a data nibble and a 2-bit destination select. Each accepted word is steered into a one-entry output slot for channel 0..3. Each channel has a wrap-around delivered-word counter for debug and bench scoreboarding.

## Interface
Parameters:
- DATA_W, 4, width of the data word.
- CNT_W, 8, width of each per-channel delivered counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  DATA_W  input word.
- in_sel  in  2  destination channel (0..3).
- out_valid  out  4  bit k: channel k slot holds a word.
- out_ready  in  4  bit k: channel k sink takes the word this cycle.
- out_data  out  4*DATA_W  channel k word at bits [k*DATA_W +: DATA_W].
- clear_counts  in  1  synchronous clear of all counters.
- out_count  out  4*CNT_W  channel k delivered count at bits [k*CNT_W +: CNT_W].

## Operation
- Input handshake: a word is accepted when in_valid & in_ready.
- Output handshake for channel k: a word is delivered when out_valid[k] & out_ready[k].
- Each slot is a two-state machine, EMPTY or FULL; FULL is equivalent to out_valid[k]=1.
- Slot transitions:
  - EMPTY→FULL on accept with in_sel=k.
  - FULL→EMPTY on delivery without an accept to k.
  - FULL→FULL with new data on a simultaneous delivery and accept to k (pass-through).
  - Otherwise the slot holds its state.
- in_ready = rst_n & (~out_valid[in_sel] | out_ready[in_sel]).
  - This is combinational and depends only on the selected channel.
  - A full, stalled channel blocks only words addressed to it.
- Source rule: in_data and in_sel stay stable while in_valid & ~in_ready.
- Sink guarantee: out_data[k] stays stable while out_valid[k] & ~out_ready[k].
- Ordering: words to the same channel are delivered in acceptance order. No word is dropped or duplicated.
- Counters:
  - out_count[k] increments by 1 on each channel-k delivery.
  - It wraps from 2^CNT_W−1 to 0.
  - clear_counts has priority: all counts become 0 even if a delivery occurs that cycle.
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_count = 0.
  - in_ready = 0 while rst_n is low.
  - A word in flight at reset is lost. Operation resumes on the first edge after release.

## Timing
- Latency: 1 cycle. A word accepted at edge N gives out_valid[k]=1 from edge N for sampling at edge N+1.
- Throughput: 1 word/cycle per channel with out_ready[k] held high, including back-to-back words to the same channel.
- Channels can deliver in parallel: up to 4 deliveries per cycle, but at most 1 accept per cycle.
- out_count[k] reflects a delivery one cycle after the delivery handshake.
- Combinational paths: out_ready→in_ready and in_sel→in_ready. All other outputs are registered.

## Structure
- Shared package demux_pkg holds:
  - NUM_CH = 4.
  - SEL_W = 2.
  - the channel-select typedef.
  - the slot state encoding (EMPTY, FULL).
- Sub-module demux_slot, instantiated NUM_CH times, contains:
  - one-entry data register and valid flag.
  - the load/drain logic.
  - CNT_W counter with clear.
- The top level contains the select decode, the in_ready mux and output packing.

## Test plan
- Reset check:
  - Stimulus: assert rst_n=0 mid-stream while slot 2 holds 4'hA and count2=5.
  - Required: out_valid=4'b0000 and out_count all 0 immediately, without a clock edge; in_ready=0 until release.
- Basic route:
  - Stimulus: all out_ready=1; send sel 0,1,2,3 with data 1,2,3,4.
  - Required: each out_valid[k] pulses one cycle later with data k+1; counts end at 1,1,1,1.
- Backpressure isolation:
  - Stimulus: out_ready[1]=0; send sel=1 data 5, then sel=1 data 6, then sel=3 data 7.
  - Required: 5 held on channel 1; in_ready=0 for the second word; the sel=3 word is not presented until the sel=1 word is accepted, so the stream stalls in order; after out_ready[1]=1, channel 1 delivers 5 then 6.
- Pass-through:
  - Stimulus: channel 2 full with 8; out_ready[2]=1 and an accept of data 9 to sel=2 in the same cycle.
  - Required: out_valid[2] stays 1, out_data[2]=9 next cycle, count2 increments by 1.
- Counter wrap/clear:
  - Stimulus: 256 deliveries on channel 0.
  - Required: count0 wraps to 0.
  - Stimulus: clear_counts asserted together with a delivery.
  - Required: count0=0.
- Random soak:
  - Stimulus: 10k cycles of random valid/sel/ready.
  - Required: scoreboard shows per-channel in-order delivery, no loss or duplication, and counts matching scoreboard totals mod 256.
